// File: rtl/frac_search_pkg.sv
// Shared constants, candidate ordering and pixel-interpolation helpers for frac_search_unit.
// FRAC_SEARCH_DIAG_EN selects the 9-candidate (diagonal) build; otherwise only the 5 axial candidates exist.
package frac_search_pkg;

    localparam int PIX_W     = 8;
    localparam int ROW_PIX   = 8;
    localparam int BLK_ROWS  = 8;
    localparam int SAD_W     = 14;
    localparam int ROW_SAD_W = 11;
    localparam int ROW_W     = PIX_W * ROW_PIX;
    localparam int ROW_CNT_W = $clog2(BLK_ROWS);

    localparam logic [2:0] MV_NEG_HALF = 3'b110;
    localparam logic [2:0] MV_ZERO     = 3'b000;
    localparam logic [2:0] MV_POS_HALF = 3'b010;

    // Candidate index in decision priority order, named (dx,dy): M = -2, 0 = 0, P = +2.
    typedef enum logic [3:0] {
        CAND_00 = 4'd0,
        CAND_M0 = 4'd1,
        CAND_P0 = 4'd2,
        CAND_0M = 4'd3,
        CAND_0P = 4'd4,
        CAND_MM = 4'd5,
        CAND_PM = 4'd6,
        CAND_MP = 4'd7,
        CAND_PP = 4'd8
    } cand_e;

`ifdef FRAC_SEARCH_DIAG_EN
    localparam int NUM_CAND = 9;
    localparam int MID_LO   = 0;
    localparam int MID_HI   = 2;
`else
    localparam int NUM_CAND = 5;
    localparam int MID_LO   = 1;
    localparam int MID_HI   = 1;
`endif

    typedef logic [PIX_W-1:0] pix_t;

    // Horizontal edge replication: indices outside 0..7 clamp to the nearest edge pixel.
    function automatic pix_t get_pix(input logic [ROW_W-1:0] row, input int idx);
        int j;
        j = (idx < 0) ? 0 : ((idx > ROW_PIX - 1) ? ROW_PIX - 1 : idx);
        return row[j*PIX_W +: PIX_W];
    endfunction

    function automatic pix_t avg2(input pix_t a, input pix_t b);
        logic [PIX_W:0] s;
        s = (PIX_W+1)'(a) + (PIX_W+1)'(b) + (PIX_W+1)'(1);
        return s[PIX_W:1];
    endfunction

    function automatic pix_t avg4(input pix_t a, input pix_t b, input pix_t c, input pix_t d);
        logic [PIX_W+1:0] s;
        s = (PIX_W+2)'(a) + (PIX_W+2)'(b) + (PIX_W+2)'(c) + (PIX_W+2)'(d) + (PIX_W+2)'(2);
        return s[PIX_W+1:2];
    endfunction

    function automatic pix_t abs_diff(input pix_t a, input pix_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // dxk: 0 -> dx=-2, 1 -> dx=0, 2 -> dx=+2
    function automatic logic [ROW_W-1:0] horiz_row(input logic [ROW_W-1:0] row, input int dxk);
        logic [ROW_W-1:0] res;
        res = '0;
        for (int i = 0; i < ROW_PIX; i++) begin
            case (dxk)
                0:       res[i*PIX_W +: PIX_W] = avg2(get_pix(row, i - 1), get_pix(row, i));
                2:       res[i*PIX_W +: PIX_W] = avg2(get_pix(row, i), get_pix(row, i + 1));
                default: res[i*PIX_W +: PIX_W] = get_pix(row, i);
            endcase
        end
        return res;
    endfunction

    // Vertical half-row between rows a (above) and b (below), optionally shifted half a pixel.
    function automatic logic [ROW_W-1:0] mid_row(input logic [ROW_W-1:0] a,
                                                 input logic [ROW_W-1:0] b,
                                                 input int dxk);
        logic [ROW_W-1:0] res;
        res = '0;
        for (int i = 0; i < ROW_PIX; i++) begin
            case (dxk)
                0:       res[i*PIX_W +: PIX_W] = avg4(get_pix(a, i - 1), get_pix(a, i),
                                                      get_pix(b, i - 1), get_pix(b, i));
                2:       res[i*PIX_W +: PIX_W] = avg4(get_pix(a, i), get_pix(a, i + 1),
                                                      get_pix(b, i), get_pix(b, i + 1));
                default: res[i*PIX_W +: PIX_W] = avg2(get_pix(a, i), get_pix(b, i));
            endcase
        end
        return res;
    endfunction

    function automatic logic [2:0] cand_mvx(input cand_e c);
        case (c)
            CAND_M0, CAND_MM, CAND_MP: return MV_NEG_HALF;
            CAND_P0, CAND_PM, CAND_PP: return MV_POS_HALF;
            default:                   return MV_ZERO;
        endcase
    endfunction

    function automatic logic [2:0] cand_mvy(input cand_e c);
        case (c)
            CAND_0M, CAND_MM, CAND_PM: return MV_NEG_HALF;
            CAND_0P, CAND_MP, CAND_PP: return MV_POS_HALF;
            default:                   return MV_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/frac_search_unit_row_sad.sv
// Row SAD: sum of absolute differences between 8 interpolated and 8 original pixels.
// Used by frac_search_unit; candidate count depends on FRAC_SEARCH_DIAG_EN in the top.
module frac_row_sad
    import frac_search_pkg::*;
(
    input  logic [ROW_W-1:0]     interp,
    input  logic [ROW_W-1:0]     orig,
    output logic [ROW_SAD_W-1:0] sad
);

    always_comb begin
        sad = '0;
        for (int i = 0; i < ROW_PIX; i++) begin
            sad = sad + ROW_SAD_W'(abs_diff(interp[i*PIX_W +: PIX_W], orig[i*PIX_W +: PIX_W]));
        end
    end

endmodule

// File: rtl/frac_search_unit.sv
// Half-pel fractional refinement of an 8x8 block, one row per accepted beat, result one cycle after row 7.
// FRAC_SEARCH_DIAG_EN adds the four diagonal candidates; undefined builds only the axial five.
module frac_search_unit
    import frac_search_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ROW_W-1:0] filter_pix,
    input  logic [ROW_W-1:0] ref_pix,
    input  logic             input_ready,
    output logic [2:0]       mvx,
    output logic [2:0]       mvy
);

    logic [ROW_CNT_W-1:0] row_cnt;
    logic [ROW_W-1:0]     prev_f;
    logic [ROW_W-1:0]     prev_o;
    logic [ROW_W-1:0]     mid_top;
    logic                 first_row;
    logic                 last_row;
    logic                 decide;

    logic [ROW_W-1:0]     h_row  [3];
    logic [ROW_W-1:0]     m_row  [MID_LO:MID_HI];
    logic [ROW_SAD_W-1:0] sad_h  [3];
    logic [ROW_SAD_W-1:0] sad_mc [MID_LO:MID_HI];
    logic [ROW_SAD_W-1:0] sad_mp [MID_LO:MID_HI];

    logic [SAD_W-1:0]     acc     [NUM_CAND];
    logic [SAD_W-1:0]     row_add [NUM_CAND];
    cand_e                best;
    logic [SAD_W-1:0]     best_sad;

    assign first_row = (row_cnt == '0);
    assign last_row  = (row_cnt == ROW_CNT_W'(BLK_ROWS - 1));
    // Row 0 has no row above: vertical replication makes F[-1] the current row.
    assign mid_top   = first_row ? filter_pix : prev_f;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            h_row[k] = horiz_row(filter_pix, k);
        end
        for (int k = MID_LO; k <= MID_HI; k++) begin
            m_row[k] = mid_row(mid_top, filter_pix, k);
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_h
        frac_row_sad u_sad (
            .interp (h_row[k]),
            .orig   (ref_pix),
            .sad    (sad_h[k])
        );
    end

    // The half-row between F[r-1] and F[r] is dy=-2 for row r and dy=+2 for row r-1.
    for (genvar k = MID_LO; k <= MID_HI; k++) begin : g_m
        frac_row_sad u_cur (
            .interp (m_row[k]),
            .orig   (ref_pix),
            .sad    (sad_mc[k])
        );
        frac_row_sad u_prev (
            .interp (m_row[k]),
            .orig   (prev_o),
            .sad    (sad_mp[k])
        );
    end

    always_comb begin
        for (int c = 0; c < NUM_CAND; c++) begin
            row_add[c] = '0;
        end
        row_add[int'(CAND_00)] = SAD_W'(sad_h[1]);
        row_add[int'(CAND_M0)] = SAD_W'(sad_h[0]);
        row_add[int'(CAND_P0)] = SAD_W'(sad_h[2]);
        row_add[int'(CAND_0M)] = SAD_W'(sad_mc[1]);
        // Row 7 of dy=+2 sees replicated F[8]=F[7], identical to the dy=0 row-7 SAD.
        row_add[int'(CAND_0P)] = (first_row ? '0 : SAD_W'(sad_mp[1]))
                               + (last_row ? SAD_W'(sad_h[1]) : '0);
`ifdef FRAC_SEARCH_DIAG_EN
        row_add[int'(CAND_MM)] = SAD_W'(sad_mc[0]);
        row_add[int'(CAND_PM)] = SAD_W'(sad_mc[2]);
        row_add[int'(CAND_MP)] = (first_row ? '0 : SAD_W'(sad_mp[0]))
                               + (last_row ? SAD_W'(sad_h[0]) : '0);
        row_add[int'(CAND_PP)] = (first_row ? '0 : SAD_W'(sad_mp[2]))
                               + (last_row ? SAD_W'(sad_h[2]) : '0);
`endif
    end

    always_comb begin
        best     = CAND_00;
        best_sad = acc[0];
        for (int c = 1; c < NUM_CAND; c++) begin
            if (acc[c] < best_sad) begin
                best     = cand_e'(c);
                best_sad = acc[c];
            end
        end
    end

    // decide fires the cycle after row 7; a new row 0 in that same cycle overwrites acc only afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt <= '0;
            prev_f  <= '0;
            prev_o  <= '0;
            decide  <= 1'b0;
            mvx     <= MV_ZERO;
            mvy     <= MV_ZERO;
            for (int c = 0; c < NUM_CAND; c++) begin
                acc[c] <= '0;
            end
        end else begin
            decide <= input_ready && last_row;
            if (input_ready) begin
                row_cnt <= row_cnt + 1'b1;
                prev_f  <= filter_pix;
                prev_o  <= ref_pix;
                for (int c = 0; c < NUM_CAND; c++) begin
                    acc[c] <= first_row ? row_add[c] : acc[c] + row_add[c];
                end
            end
            if (decide) begin
                mvx <= cand_mvx(best);
                mvy <= cand_mvy(best);
            end
        end
    end

endmodule

// File: tb/tb_frac_search_unit.sv
// Bench for frac_search_unit: block-level SAD model over whole 8x8 blocks, checked every cycle.
// Follows FRAC_SEARCH_DIAG_EN to know how many candidates the decision may choose from.
module tb_frac_search_unit;

    typedef logic [63:0] rows_t [8];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] filter_pix = '0;
    logic [63:0] ref_pix = '0;
    logic        input_ready = 1'b0;
    logic [2:0]  mvx;
    logic [2:0]  mvy;

    frac_search_unit dut (
        .clk         (clk),
        .reset       (reset),
        .filter_pix  (filter_pix),
        .ref_pix     (ref_pix),
        .input_ready (input_ready),
        .mvx         (mvx),
        .mvy         (mvy)
    );

    always #5 clk = ~clk;

`ifdef FRAC_SEARCH_DIAG_EN
    localparam int NC = 9;
`else
    localparam int NC = 5;
`endif
    int cdx [9] = '{0, -2, 2, 0, 0, -2, 2, -2, 2};
    int cdy [9] = '{0, 0, 0, -2, 2, -2, -2, 2, 2};

    int total = 0;
    int bad = 0;
    logic checking = 1'b0;
    rows_t sf, so;

    function automatic int px(rows_t f, int r, int c);
        int rr, cc;
        rr = (r < 0) ? 0 : ((r > 7) ? 7 : r);
        cc = (c < 0) ? 0 : ((c > 7) ? 7 : c);
        return int'(f[rr][cc*8 +: 8]);
    endfunction

    // Predicted pixel for candidate (dx,dy) at block position (r,i), from the integer neighbours.
    function automatic int pred(rows_t f, int dx, int dy, int r, int i);
        int r0, r1, c0, c1;
        r0 = (dy < 0) ? r - 1 : r;
        r1 = (dy > 0) ? r + 1 : r;
        c0 = (dx < 0) ? i - 1 : i;
        c1 = (dx > 0) ? i + 1 : i;
        if (dx != 0 && dy != 0)
            return (px(f, r0, c0) + px(f, r0, c1) + px(f, r1, c0) + px(f, r1, c1) + 2) >> 2;
        if (dx != 0) return (px(f, r, c0) + px(f, r, c1) + 1) >> 1;
        if (dy != 0) return (px(f, r0, i) + px(f, r1, i) + 1) >> 1;
        return px(f, r, i);
    endfunction

    function automatic int blk_sad(rows_t f, rows_t o, int cand);
        int s, d;
        s = 0;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                d = pred(f, cdx[cand], cdy[cand], r, i) - px(o, r, i);
                s += (d < 0) ? -d : d;
            end
        end
        return s;
    endfunction

    function automatic int best_cand(rows_t f, rows_t o);
        int b, bs, s;
        b = 0;
        bs = blk_sad(f, o, 0);
        for (int c = 1; c < NC; c++) begin
            s = blk_sad(f, o, c);
            if (s < bs) begin
                b = c;
                bs = s;
            end
        end
        return b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect accepted rows, decide on row 7, publish one edge later.
    rows_t       mf, mo;
    int          mcnt = 0;
    logic        pend = 1'b0;
    logic [2:0]  nx = '0, ny = '0;
    logic [2:0]  exp_x = '0, exp_y = '0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            mcnt = 0;
            pend = 1'b0;
            exp_x = '0;
            exp_y = '0;
        end else if (clk) begin
            if (pend) begin
                exp_x = nx;
                exp_y = ny;
                pend = 1'b0;
            end
            if (input_ready) begin
                mf[mcnt] = filter_pix;
                mo[mcnt] = ref_pix;
                if (mcnt == 7) begin
                    int b;
                    b = best_cand(mf, mo);
                    nx = 3'(cdx[b]);
                    ny = 3'(cdy[b]);
                    pend = 1'b1;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            check("mvx_cycle", int'(mvx), int'(exp_x));
            check("mvy_cycle", int'(mvy), int'(exp_y));
        end
    end

    task automatic beat(input logic [63:0] f, input logic [63:0] o);
        filter_pix = f;
        ref_pix = o;
        input_ready = 1'b1;
        @(negedge clk);
        input_ready = 1'b0;
        filter_pix = {$urandom(), $urandom()};
        ref_pix = {$urandom(), $urandom()};
    endtask

    task automatic send_block(input int gap_max);
        for (int r = 0; r < 8; r++) begin
            beat(sf[r], so[r]);
            if (r < 7) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
    endtask

    task automatic send_block_gap(input int gap);
        for (int r = 0; r < 8; r++) begin
            beat(sf[r], so[r]);
            if (r < 7) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic make_flat();
        for (int r = 0; r < 8; r++) begin
            sf[r] = {8{8'h40}};
            so[r] = {8{8'h40}};
        end
    endtask

    task automatic make_hramp();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                sf[r][i*8 +: 8] = 8'(16 * i);
                so[r][i*8 +: 8] = 8'(16 * i + 8);
            end
        end
    endtask

    task automatic make_vramp();
        for (int r = 0; r < 8; r++) begin
            sf[r] = {8{8'(16 * r)}};
            so[r] = {8{8'(16 * r + 8)}};
        end
    endtask

    // Sparse bright pixels: the 2x2 diagonal average fits the 50-valued original best.
    task automatic make_diag();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                sf[r][i*8 +: 8] = ((r % 2 == 1) && (i % 2 == 1)) ? 8'd200 : 8'd0;
                so[r][i*8 +: 8] = 8'd50;
            end
        end
    endtask

    task automatic make_random_near();
        int c, v;
        c = $urandom_range(0, 8);
        for (int r = 0; r < 8; r++) sf[r] = {$urandom(), $urandom()};
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                v = pred(sf, cdx[c], cdy[c], r, i) + $urandom_range(0, 3);
                so[r][i*8 +: 8] = 8'((v > 255) ? 255 : v);
            end
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checking = 1'b1;

        make_flat();
        check("model_flat_sad00", blk_sad(sf, so, 0), 0);
        make_hramp();
        check("model_hramp_sad00", blk_sad(sf, so, 0), 512);
        check("model_hramp_sadP0", blk_sad(sf, so, 2), 64);
        make_vramp();
        check("model_vramp_sad0P", blk_sad(sf, so, 4), 64);
        check("model_vramp_sad0M", blk_sad(sf, so, 3), 960);

        make_flat();
        send_block_gap(0);
        @(negedge clk);
        check("flat_mvx", int'(mvx), 0);
        check("flat_mvy", int'(mvy), 0);

        make_flat();
        send_block_gap(0);
        make_hramp();
        send_block_gap(0);
        check("b2b_not_yet_mvx", int'(mvx), 0);
        @(negedge clk);
        check("b2b_mvx", int'(mvx), 2);
        check("b2b_mvy", int'(mvy), 0);

        make_vramp();
        send_block_gap(0);
        @(negedge clk);
        check("vramp_mvx", int'(mvx), 0);
        check("vramp_mvy", int'(mvy), 2);

        make_hramp();
        send_block_gap(3);
        @(negedge clk);
        check("gap_mvx", int'(mvx), 2);
        check("gap_mvy", int'(mvy), 0);

        make_hramp();
        for (int r = 0; r < 3; r++) beat(sf[r], so[r]);
        #2 reset = 1'b0;
        #1 check("reset_async_mvx", int'(mvx), 0);
        check("reset_async_mvy", int'(mvy), 0);
        @(negedge clk);
        reset = 1'b1;
        make_vramp();
        send_block_gap(0);
        @(negedge clk);
        check("after_reset_mvy", int'(mvy), 2);

        make_diag();
        send_block_gap(0);
        @(negedge clk);
`ifndef FRAC_SEARCH_DIAG_EN
        check("axial_only_x", ((mvx == 3'b000) || (mvy == 3'b000)) ? 1 : 0, 1);
`endif

        for (int b = 0; b < 24; b++) begin
            make_random_near();
            send_block(2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frac_search_unit.md
# frac_search_unit

Half-pel fractional motion refinement for an 8x8 block. It streams one row per beat: 8 integer-position reference pixels plus 8 original pixels. It bilinearly interpolates the ±½-pel candidates, accumulates SAD per candidate over 8 rows, and outputs the best fractional vector in quarter-pel units. It sits after integer motion search, fed one row per accepted beat.

## Interface
- No parameters; constants live in the package.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `filter_pix`  in  64  integer reference row; pixel i = bits [8i+7:8i], i=0..7, unsigned.
- `ref_pix`  in  64  original (current-block) row, same packing.
- `input_ready`  in  1  beat valid; row sampled on a rising edge while high.
- `mvx`  out  3  best horizontal offset, two's complement quarter-pel: 3'b110 (−2), 3'b000 (0), 3'b010 (+2).
- `mvy`  out  3  best vertical offset, same encoding.

## Operation
- Row counter r (0..7) advances only on accepted beats and wraps 7→0; 8 beats form one block.
- F[r] is the filter row; O[r] is the original row. Rows are edge-replicated:
  - horizontal: p[−1]=p[0], p[8]=p[7];
  - vertical: F[−1]=F[0], F[8]=F[7].
- Interpolation, integer, rounded:
  - half: (a+b+1)>>1;
  - diagonal: (a+b+c+d+2)>>2 from the four integer neighbours.
  - dx=−2 uses pixels i−1,i; dx=+2 uses i,i+1; dy=−2 uses rows r−1,r; dy=+2 uses rows r,r+1.
- Per beat r:
  - form the interpolated rows from F[r] and a vertical half-row between F[r−1] and F[r];
  - rows with dy∈{0,−2} are compared with O[r];
  - rows with dy=+2 are compared with stored O[r−1] when r≥1;
  - at r=7, add the dy=0 row-7 SADs also to the dy=+2 accumulators (replicated F[8]).
- Stored state: previous F and previous O row.
- SAD accumulators: 14-bit unsigned, one per candidate; loaded, not added, at r=0.
- Decision:
  - minimum SAD with a strict less-than scan in priority order (0,0),(−2,0),(+2,0),(0,−2),(0,+2),(−2,−2),(+2,−2),(−2,+2),(+2,+2) as (dx,dy);
  - ties resolve to the earlier entry.
- Outputs are registered and hold their value between decisions.

## Timing
- Reset asserted: mvx=mvy=0, r=0, accumulators and stored rows cleared, immediately (asynchronous).
- Reset mid-block discards the partial block.
- The 8th beat is sampled at edge t; mvx/mvy update at edge t+1 (latency 1 cycle).
- A beat 0 of the next block at t+1 is accepted in the same cycle; the decision reads pre-overwrite accumulator values.
- input_ready low: no state change; outputs hold.
- Gaps between beats are allowed and do not affect results.
- Throughput: one row per cycle, sustained.

## Configuration
- `FRAC_SEARCH_DIAG_EN` defined: all 9 candidates, including diagonals.
- Undefined: only the 5 candidates (0,0),(±2,0),(0,±2); diagonal interpolators and accumulators are not built; priority order is otherwise unchanged.

## Structure
- Package `frac_search_pkg`:
  - PIX_W=8, ROW_PIX=8, BLK_ROWS=8, SAD_W=14;
  - MV encodings (MV_NEG_HALF, MV_ZERO, MV_POS_HALF);
  - candidate index enum in priority order.
- Sub-module `frac_row_sad`: 8 interpolated pixels vs 8 original pixels → 11-bit row SAD. Instantiated once per candidate path.

## Test plan
- Reset low mid-stream → mvx=mvy=3'b000 immediately; the next block's result is computed from its own 8 beats only.
- Flat block, all pixels 0x40 for 8 beats → all SADs 0; tie resolves to mvx=0, mvy=0 one cycle after beat 8.
- Horizontal ramp: every F row = 0x00,0x10,…,0x70 and O row = 0x08,…,0x78 → mvx=3'b010, mvy=3'b000.
  - Expected SADs: 64 for (+2,0) vs 512 for (0,0).
- Vertical ramp: F row r all 0x10·r, O row r all 0x10·r+8 → mvx=3'b000, mvy=3'b010.
  - Row 7 uses the replicated F[8].
- Ramp stimulus with input_ready low for 3 cycles between beats → same result as contiguous; outputs unchanged during gaps.
- Two back-to-back blocks (flat, then horizontal ramp) → (0,0) after block 1, then (+2,0) exactly one cycle after block 2's 8th beat.
- Macro undefined, diagonal-favouring data → result restricted to the 5 axial candidates.
